// File: rtl/kvs_bucket_if.sv
// Request/response bundle for kvs_bucket: valid/ready request channel and a
// one-cycle response pulse with no backpressure.
interface kvs_bucket_if #(
  parameter int NUM_KEY_BITS = 32,
  parameter int NUM_VAL_BITS = 32
);
  logic                    req_valid;
  logic                    req_ready;
  logic [1:0]              req_op;
  logic [NUM_KEY_BITS-1:0] req_key;
  logic [NUM_VAL_BITS-1:0] req_value;
  logic                    rsp_valid;
  logic [1:0]              rsp_status;
  logic [NUM_VAL_BITS-1:0] rsp_value;

  modport master (
    output req_valid, req_op, req_key, req_value,
    input  req_ready, rsp_valid, rsp_status, rsp_value
  );

  modport slave (
    input  req_valid, req_op, req_key, req_value,
    output req_ready, rsp_valid, rsp_status, rsp_value
  );
endinterface

// File: rtl/kvs_bucket.sv
// Set-associative key/value store: NUM_WAYS entries per bucket, 2-cycle response
// pipeline with bucket-row forwarding, and a sweep FSM that invalidates memory.

module kvs_bucket_way #(
  parameter int NUM_KEY_BITS = 32
) (
  input  logic                    vld_i,
  input  logic [NUM_KEY_BITS-1:0] key_i,
  input  logic [NUM_KEY_BITS-1:0] req_key_i,
  output logic                    hit_o
);
  assign hit_o = vld_i && (key_i == req_key_i);
endmodule

module kvs_bucket_crc #(
  parameter int NUM_ADDR_BITS = 10,
  parameter int NUM_KEY_BITS  = 32
) (
  input  logic [NUM_KEY_BITS-1:0]  key_i,
  output logic [NUM_ADDR_BITS-1:0] idx_o
);
  localparam logic [31:0] POLY = 32'h04c11db7;
  logic [31:0] crc;
  logic        fb;

  // MSB-first, zero-seeded, unreflected CRC-32 over the key bits
  always_comb begin
    crc = '0;
    fb  = 1'b0;
    for (int i = NUM_KEY_BITS - 1; i >= 0; i--) begin
      fb  = crc[31] ^ key_i[i];
      crc = {crc[30:0], 1'b0};
      if (fb) crc = crc ^ POLY;
    end
    idx_o = crc[NUM_ADDR_BITS-1:0];
  end
endmodule

module kvs_bucket #(
  parameter int NUM_WAYS      = 4,
  parameter int NUM_ADDR_BITS = 10,
  parameter int NUM_KEY_BITS  = 32,
  parameter int NUM_VAL_BITS  = 32,
  parameter int HASH_SEL      = 0
) (
  input  logic clk,
  input  logic rst_n,
  kvs_bucket_if.slave bus,
  output logic [$clog2(NUM_WAYS*(2**NUM_ADDR_BITS)+1)-1:0] count_o,
  output logic init_done_o
);
  localparam int DEPTH = 2**NUM_ADDR_BITS;
  localparam int CW    = $clog2(NUM_WAYS*DEPTH+1);

  typedef enum logic [1:0] {OP_LOOKUP = 2'd0, OP_UPSERT = 2'd1, OP_DELETE = 2'd2, OP_CLEAR = 2'd3} op_e;
  typedef enum logic [1:0] {ST_OK = 2'd0, ST_MISS = 2'd1, ST_FULL = 2'd2} status_e;
  typedef enum logic [1:0] {S_SWEEP, S_RUN, S_DRAIN, S_CLRRSP} state_e;

  typedef struct packed {
    logic [NUM_WAYS-1:0]                   vld;
    logic [NUM_WAYS-1:0][NUM_KEY_BITS-1:0] key;
    logic [NUM_WAYS-1:0][NUM_VAL_BITS-1:0] val;
  } row_t;

  typedef struct packed {
    op_e                      op;
    logic [NUM_KEY_BITS-1:0]  key;
    logic [NUM_VAL_BITS-1:0]  val;
    logic [NUM_ADDR_BITS-1:0] idx;
  } req_t;

  state_e                   state_q, state_d;
  logic [NUM_ADDR_BITS-1:0] swp_addr_q, swp_addr_d;
  logic                     swp_clr_q, swp_clr_d;
  logic                     swp_done;
  logic                     init_done_q;

  logic                     acc;
  logic [NUM_ADDR_BITS-1:0] req_idx;

  logic                     s1_vld_q;
  req_t                     s1_q;
  row_t                     rd_row_q, fwd_row_q;
  logic                     fwd_q;
  row_t                     cur_row, new_row;
  logic [NUM_WAYS-1:0]      hit;
  status_e                  st_d;
  logic [NUM_VAL_BITS-1:0]  val_d;
  logic                     inc, dec, placed;

  logic                     mem_we;
  logic [NUM_ADDR_BITS-1:0] mem_waddr;
  row_t                     mem_wdata;
  row_t                     mem [DEPTH];

  logic                     rsp_valid_q;
  status_e                  rsp_status_q;
  logic [NUM_VAL_BITS-1:0]  rsp_value_q;
  logic [CW-1:0]            count_q;

  assign bus.req_ready  = (state_q == S_RUN);
  assign acc            = bus.req_valid && bus.req_ready;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_status = rsp_status_q;
  assign bus.rsp_value  = rsp_value_q;
  assign count_o        = count_q;
  assign init_done_o    = init_done_q;

  generate
    if (HASH_SEL == 0) begin : g_crc
      kvs_bucket_crc #(.NUM_ADDR_BITS(NUM_ADDR_BITS), .NUM_KEY_BITS(NUM_KEY_BITS)) u_crc (
        .key_i (bus.req_key),
        .idx_o (req_idx)
      );
    end else begin : g_low
      assign req_idx = bus.req_key[NUM_ADDR_BITS-1:0];
    end
  endgenerate

  // Sweep / run control
  always_comb begin
    state_d    = state_q;
    swp_addr_d = swp_addr_q;
    swp_clr_d  = swp_clr_q;
    swp_done   = 1'b0;
    case (state_q)
      S_SWEEP: begin
        swp_addr_d = swp_addr_q + NUM_ADDR_BITS'(1);
        if (swp_addr_q == '1) begin
          swp_done = 1'b1;
          state_d  = swp_clr_q ? S_CLRRSP : S_RUN;
        end
      end
      S_RUN:    if (acc && (bus.req_op == OP_CLEAR)) state_d = S_DRAIN;
      S_DRAIN: begin
        if (!s1_vld_q) begin
          state_d    = S_SWEEP;
          swp_clr_d  = 1'b1;
          swp_addr_d = '0;
        end
      end
      S_CLRRSP: begin
        state_d   = S_RUN;
        swp_clr_d = 1'b0;
      end
      default:  state_d = S_SWEEP;
    endcase
  end

  // A same-bucket predecessor wrote this row last cycle; memory returned stale data
  assign cur_row = fwd_q ? fwd_row_q : rd_row_q;

  generate
    for (genvar w = 0; w < NUM_WAYS; w++) begin : g_way
      kvs_bucket_way #(.NUM_KEY_BITS(NUM_KEY_BITS)) u_way (
        .vld_i     (cur_row.vld[w]),
        .key_i     (cur_row.key[w]),
        .req_key_i (s1_q.key),
        .hit_o     (hit[w])
      );
    end
  endgenerate

  always_comb begin
    new_row = cur_row;
    st_d    = ST_OK;
    val_d   = '0;
    inc     = 1'b0;
    dec     = 1'b0;
    placed  = 1'b0;
    case (s1_q.op)
      OP_LOOKUP: begin
        if (|hit) begin
          for (int w = 0; w < NUM_WAYS; w++)
            if (hit[w]) val_d = cur_row.val[w];
        end else begin
          st_d = ST_MISS;
        end
      end
      OP_UPSERT: begin
        if (|hit) begin
          for (int w = 0; w < NUM_WAYS; w++)
            if (hit[w]) new_row.val[w] = s1_q.val;
        end else begin
          for (int w = 0; w < NUM_WAYS; w++) begin
            if (!placed && !cur_row.vld[w]) begin
              new_row.vld[w] = 1'b1;
              new_row.key[w] = s1_q.key;
              new_row.val[w] = s1_q.val;
              placed         = 1'b1;
            end
          end
          if (placed) inc  = 1'b1;
          else        st_d = ST_FULL;
        end
      end
      OP_DELETE: begin
        if (|hit) begin
          for (int w = 0; w < NUM_WAYS; w++)
            if (hit[w]) new_row.vld[w] = 1'b0;
          dec = 1'b1;
        end else begin
          st_d = ST_MISS;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = s1_q.idx;
    mem_wdata = new_row;
    if (state_q == S_SWEEP) begin
      mem_we    = 1'b1;
      mem_waddr = swp_addr_q;
      mem_wdata = '0;
    end else if (s1_vld_q && (s1_q.op == OP_UPSERT || s1_q.op == OP_DELETE)) begin
      mem_we = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
    rd_row_q <= mem[req_idx];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_SWEEP;
      swp_addr_q   <= '0;
      swp_clr_q    <= 1'b0;
      init_done_q  <= 1'b0;
      s1_vld_q     <= 1'b0;
      s1_q         <= '0;
      fwd_q        <= 1'b0;
      fwd_row_q    <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_status_q <= ST_OK;
      rsp_value_q  <= '0;
      count_q      <= '0;
    end else begin
      state_q    <= state_d;
      swp_addr_q <= swp_addr_d;
      swp_clr_q  <= swp_clr_d;
      if (swp_done) init_done_q <= 1'b1;
      s1_vld_q <= acc && (bus.req_op != OP_CLEAR);
      if (acc) begin
        s1_q.op  <= op_e'(bus.req_op);
        s1_q.key <= bus.req_key;
        s1_q.val <= bus.req_value;
        s1_q.idx <= req_idx;
      end
      fwd_q        <= acc && s1_vld_q && (req_idx == s1_q.idx);
      fwd_row_q    <= new_row;
      rsp_valid_q  <= s1_vld_q || (swp_done && swp_clr_q);
      rsp_status_q <= s1_vld_q ? st_d : ST_OK;
      rsp_value_q  <= s1_vld_q ? val_d : '0;
      if (swp_done && swp_clr_q) count_q <= '0;
      else if (s1_vld_q)         count_q <= count_q + CW'(inc) - CW'(dec);
    end
  end
endmodule

// File: tb/tb_kvs_bucket.sv
// Directed bench for kvs_bucket: 16 buckets x 2 ways, 8-bit keys/values,
// key-low-bits hashing so bucket numbers can be chosen by hand.
module tb_kvs_bucket;
  localparam int A = 4, W = 2, K = 8, V = 8, CW = 6;
  localparam logic [1:0] OP_LOOKUP = 2'd0, OP_UPSERT = 2'd1, OP_DELETE = 2'd2, OP_CLEAR = 2'd3;
  localparam logic [1:0] ST_OK = 2'd0, ST_MISS = 2'd1, ST_FULL = 2'd2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [CW-1:0] count;
  logic          init_done;
  int            vec_cnt = 0;
  int            err_cnt = 0;

  kvs_bucket_if #(.NUM_KEY_BITS(K), .NUM_VAL_BITS(V)) bus ();

  kvs_bucket #(
    .NUM_WAYS(W), .NUM_ADDR_BITS(A), .NUM_KEY_BITS(K), .NUM_VAL_BITS(V), .HASH_SEL(1)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .count_o     (count),
    .init_done_o (init_done)
  );

  always #5 clk = ~clk;

  // {rsp_valid, rsp_status, rsp_value, count}
  wire [16:0] obs = {bus.rsp_valid, bus.rsp_status, bus.rsp_value, count};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] op, input logic [7:0] key, input logic [7:0] val);
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_key   = key;
    bus.req_value = val;
  endtask

  task automatic idle();
    bus.req_valid = 1'b0;
    bus.req_op    = 2'd0;
    bus.req_key   = 8'h00;
    bus.req_value = 8'h00;
  endtask

  task automatic test_reset();
    idle();
    #2 rst_n = 1'b0;
    tick(); tick();
    vec_cnt++;
    if ({bus.req_ready, init_done, obs} !== 19'd0) begin
      err_cnt++; $display("FAIL reset_vals: got %h want 0", {bus.req_ready, init_done, obs});
    end
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      vec_cnt++;
      if ({bus.req_ready, init_done} !== 2'b00) begin
        err_cnt++; $display("FAIL reset_wait cycle %0d: ready/init got %b want 00", i, {bus.req_ready, init_done});
      end
      tick();
    end
    vec_cnt++;
    if ({bus.req_ready, init_done} !== 2'b11) begin
      err_cnt++; $display("FAIL reset_ready: ready/init got %b want 11", {bus.req_ready, init_done});
    end
    drive(OP_LOOKUP, 8'h05, 8'h00); tick(); idle(); tick();
    vec_cnt++;
    if (obs !== {1'b1, ST_MISS, 8'h00, 6'd0}) begin
      err_cnt++; $display("FAIL reset_lookup: got %h want %h", obs, {1'b1, ST_MISS, 8'h00, 6'd0});
    end
  endtask

  task automatic test_forwarding();
    tick();
    drive(OP_UPSERT, 8'h13, 8'hAA); tick();
    drive(OP_LOOKUP, 8'h13, 8'h00); tick();
    idle();
    vec_cnt++;
    if (obs !== {1'b1, ST_OK, 8'h00, 6'd1}) begin
      err_cnt++; $display("FAIL fwd_upsert: got %h want %h", obs, {1'b1, ST_OK, 8'h00, 6'd1});
    end
    tick();
    vec_cnt++;
    if (obs !== {1'b1, ST_OK, 8'hAA, 6'd1}) begin
      err_cnt++; $display("FAIL fwd_lookup: got %h want %h", obs, {1'b1, ST_OK, 8'hAA, 6'd1});
    end
  endtask

  task automatic test_full_bucket();
    tick();
    drive(OP_UPSERT, 8'h13, 8'hAA); tick();
    drive(OP_UPSERT, 8'h23, 8'hC3); tick();
    drive(OP_UPSERT, 8'h33, 8'hD3);
    vec_cnt++;
    if (obs !== {1'b1, ST_OK, 8'h00, 6'd1}) begin
      err_cnt++; $display("FAIL full_up13: got %h want %h", obs, {1'b1, ST_OK, 8'h00, 6'd1});
    end
    tick(); idle();
    vec_cnt++;
    if (obs !== {1'b1, ST_OK, 8'h00, 6'd2}) begin
      err_cnt++; $display("FAIL full_up23: got %h want %h", obs, {1'b1, ST_OK, 8'h00, 6'd2});
    end
    tick();
    vec_cnt++;
    if (obs !== {1'b1, ST_FULL, 8'h00, 6'd2}) begin
      err_cnt++; $display("FAIL full_up33: got %h want %h", obs, {1'b1, ST_FULL, 8'h00, 6'd2});
    end
    drive(OP_LOOKUP, 8'h33, 8'h00); tick(); idle(); tick();
    vec_cnt++;
    if (obs !== {1'b1, ST_MISS, 8'h00, 6'd2}) begin
      err_cnt++; $display("FAIL full_lk33: got %h want %h", obs, {1'b1, ST_MISS, 8'h00, 6'd2});
    end
  endtask

  task automatic test_overwrite_reuse();
    tick();
    drive(OP_UPSERT, 8'h13, 8'hBB); tick();
    drive(OP_LOOKUP, 8'h13, 8'h00); tick(); idle();
    vec_cnt++;
    if (obs !== {1'b1, ST_OK, 8'h00, 6'd2}) begin
      err_cnt++; $display("FAIL ow_upsert: got %h want %h", obs, {1'b1, ST_OK, 8'h00, 6'd2});
    end
    tick();
    vec_cnt++;
    if (obs !== {1'b1, ST_OK, 8'hBB, 6'd2}) begin
      err_cnt++; $display("FAIL ow_lookup: got %h want %h", obs, {1'b1, ST_OK, 8'hBB, 6'd2});
    end
    drive(OP_DELETE, 8'h13, 8'h00); tick();
    drive(OP_UPSERT, 8'h33, 8'h77); tick();
    drive(OP_LOOKUP, 8'h33, 8'h00);
    vec_cnt++;
    if (obs !== {1'b1, ST_OK, 8'h00, 6'd1}) begin
      err_cnt++; $display("FAIL reuse_delete: got %h want %h", obs, {1'b1, ST_OK, 8'h00, 6'd1});
    end
    tick();
    drive(OP_LOOKUP, 8'h23, 8'h00);
    vec_cnt++;
    if (obs !== {1'b1, ST_OK, 8'h00, 6'd2}) begin
      err_cnt++; $display("FAIL reuse_upsert: got %h want %h", obs, {1'b1, ST_OK, 8'h00, 6'd2});
    end
    tick();
    drive(OP_DELETE, 8'h44, 8'h00);
    vec_cnt++;
    if (obs !== {1'b1, ST_OK, 8'h77, 6'd2}) begin
      err_cnt++; $display("FAIL reuse_lk33: got %h want %h", obs, {1'b1, ST_OK, 8'h77, 6'd2});
    end
    tick(); idle();
    vec_cnt++;
    if (obs !== {1'b1, ST_OK, 8'hC3, 6'd2}) begin
      err_cnt++; $display("FAIL reuse_lk23: got %h want %h", obs, {1'b1, ST_OK, 8'hC3, 6'd2});
    end
    tick();
    vec_cnt++;
    if (obs !== {1'b1, ST_MISS, 8'h00, 6'd2}) begin
      err_cnt++; $display("FAIL del_miss: got %h want %h", obs, {1'b1, ST_MISS, 8'h00, 6'd2});
    end
  endtask

  task automatic test_clear();
    int low = 0;
    int hi  = 0;
    bit got = 1'b0;
    tick();
    drive(OP_CLEAR, 8'h00, 8'h00); tick(); idle();
    for (int i = 0; i < 100 && !got; i++) begin
      if (bus.req_ready) hi++; else low++;
      if (bus.rsp_valid) got = 1'b1;
      else tick();
    end
    vec_cnt++;
    if (!got) begin
      err_cnt++; $display("FAIL clear_timeout: no response within 100 cycles");
    end
    vec_cnt++;
    if (obs !== {1'b1, ST_OK, 8'h00, 6'd0}) begin
      err_cnt++; $display("FAIL clear_rsp: got %h want %h", obs, {1'b1, ST_OK, 8'h00, 6'd0});
    end
    vec_cnt++;
    if (low < 17 || hi != 0) begin
      err_cnt++; $display("FAIL clear_ready_low: low cycles %0d high cycles %0d, want >=17 and 0", low, hi);
    end
    tick();
    vec_cnt++;
    if ({bus.req_ready, bus.rsp_valid} !== 2'b10) begin
      err_cnt++; $display("FAIL clear_after: ready/rsp_valid got %b want 10", {bus.req_ready, bus.rsp_valid});
    end
    drive(OP_LOOKUP, 8'h23, 8'h00); tick();
    drive(OP_LOOKUP, 8'h33, 8'h00); tick(); idle();
    vec_cnt++;
    if (obs !== {1'b1, ST_MISS, 8'h00, 6'd0}) begin
      err_cnt++; $display("FAIL clear_lk23: got %h want %h", obs, {1'b1, ST_MISS, 8'h00, 6'd0});
    end
    tick();
    vec_cnt++;
    if (obs !== {1'b1, ST_MISS, 8'h00, 6'd0}) begin
      err_cnt++; $display("FAIL clear_lk33: got %h want %h", obs, {1'b1, ST_MISS, 8'h00, 6'd0});
    end
  endtask

  task automatic test_reset_mid();
    int seen = 0;
    tick();
    drive(OP_UPSERT, 8'h01, 8'h11); tick(); idle(); tick();
    vec_cnt++;
    if (obs !== {1'b1, ST_OK, 8'h00, 6'd1}) begin
      err_cnt++; $display("FAIL mid_pre: got %h want %h", obs, {1'b1, ST_OK, 8'h00, 6'd1});
    end
    drive(OP_UPSERT, 8'h55, 8'h66); tick(); idle();
    rst_n = 1'b0;
    #1;
    vec_cnt++;
    if ({bus.req_ready, init_done, obs} !== 19'd0) begin
      err_cnt++; $display("FAIL mid_reset_vals: got %h want 0", {bus.req_ready, init_done, obs});
    end
    tick();
    if (bus.rsp_valid) seen++;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (bus.rsp_valid) seen++;
      tick();
    end
    vec_cnt++;
    if (seen != 0) begin
      err_cnt++; $display("FAIL mid_no_rsp: got %0d responses want 0", seen);
    end
    vec_cnt++;
    if ({bus.req_ready, init_done} !== 2'b11) begin
      err_cnt++; $display("FAIL mid_ready: ready/init got %b want 11", {bus.req_ready, init_done});
    end
    drive(OP_LOOKUP, 8'h01, 8'h00); tick();
    drive(OP_LOOKUP, 8'h55, 8'h00); tick(); idle();
    vec_cnt++;
    if (obs !== {1'b1, ST_MISS, 8'h00, 6'd0}) begin
      err_cnt++; $display("FAIL mid_lk01: got %h want %h", obs, {1'b1, ST_MISS, 8'h00, 6'd0});
    end
    tick();
    vec_cnt++;
    if (obs !== {1'b1, ST_MISS, 8'h00, 6'd0}) begin
      err_cnt++; $display("FAIL mid_lk55: got %h want %h", obs, {1'b1, ST_MISS, 8'h00, 6'd0});
    end
  endtask

  task automatic test_reset_sweep();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 9; i++) tick();
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      vec_cnt++;
      if ({bus.req_ready, init_done} !== 2'b00) begin
        err_cnt++; $display("FAIL sweep9_wait cycle %0d: ready/init got %b want 00", i, {bus.req_ready, init_done});
      end
      tick();
    end
    vec_cnt++;
    if ({bus.req_ready, init_done} !== 2'b11) begin
      err_cnt++; $display("FAIL sweep9_ready: ready/init got %b want 11", {bus.req_ready, init_done});
    end
    drive(OP_UPSERT, 8'h21, 8'h5A); tick();
    drive(OP_LOOKUP, 8'h21, 8'h00); tick(); idle(); tick();
    vec_cnt++;
    if (obs !== {1'b1, ST_OK, 8'h5A, 6'd1}) begin
      err_cnt++; $display("FAIL sweep9_lk21: got %h want %h", obs, {1'b1, ST_OK, 8'h5A, 6'd1});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    idle();
    test_reset();
    test_forwarding();
    test_full_bucket();
    test_overwrite_reuse();
    test_clear();
    test_reset_mid();
    test_reset_sweep();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
